instr_fetch_unit: RTL

// Front end of the pipelined 16-bit CPU: generates the PC, requests instructions from
// a synchronous instruction memory, buffers returned words and presents them, one per

---
 rtl/instr_fetch_unit.sv | 78 +++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, instruction memory requests, fetch buffer and redirect flush
module instr_fetch_unit #(
   parameter int ADDR_W = 16,
   parameter int INSTR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               dec_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
   logic inflight_q, inflight_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0] occ;
   logic pop, push;
   logic [ADDR_W-1:0] buf_pc_q [DEPTH];
   logic [ADDR_W-1:0] buf_pc_d [DEPTH];
   logic [INSTR_W-1:0] buf_instr_q [DEPTH];
   logic [INSTR_W-1:0] buf_instr_d [DEPTH];

   always_comb begin
      instr_valid = cnt_q != '0;
      instr = instr_valid ? buf_instr_q[rd_q] : '0;
      instr_pc = instr_valid ? buf_pc_q[rd_q] : '0;
      pop = instr_valid & dec_ready & ~redirect;
      push = inflight_q & ~redirect;
      occ = (CW+1)'(cnt_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
      imem_req = ~reset & ~redirect & (occ < (CW+1)'(DEPTH));
      imem_addr = pc_q;
      pc_d = redirect ? redirect_pc : imem_req ? pc_q + ADDR_W'(1) : pc_q;
      inflight_d = imem_req;
      inflight_pc_d = imem_req ? pc_q : inflight_pc_q;
      cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
      rd_d = redirect ? '0 : rd_q + PW'(pop);
      wr_d = redirect ? '0 : wr_q + PW'(push);
      buf_pc_d = buf_pc_q;
      buf_instr_d = buf_instr_q;
      if (push) begin
         buf_pc_d[wr_q] = inflight_pc_q;
         buf_instr_d[wr_q] = imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         inflight_pc_q <= '0;
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q <= pc_d;
         inflight_q <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      buf_pc_q <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
   end
endmodule
